// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter between instruction fetch and MEM-stage load/store
// Data wins contention until STARVE_LIMIT consecutive data grants have delayed a pending fetch.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_data,
    output logic        if_ack,
    input  logic [1:0]  mem_wr,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_ack,
    output logic        stall_req,
    output logic        ram_ce,
    output logic        ram_we,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RESP    = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_MEM  = 2'd2
    } owner_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      r_state;
    owner_t      r_owner;
    logic [3:0]  r_starve_cnt;
    logic [15:0] r_if_data;
    logic [15:0] r_mem_rdata;
    logic        r_if_ack;
    logic        r_mem_ack;

    logic w_idle;
    logic w_data_pend;
    logic w_starved;
    logic w_grant_if;
    logic w_grant_mem;
    logic w_store;

    // Encodings 00 (load) and 01 (store) are the only live data ops; 1x is idle.
    assign w_idle      = (r_state == ST_IDLE);
    assign w_data_pend = ~mem_wr[1];
    assign w_starved   = (r_starve_cnt == LIMIT);
    assign w_grant_if  = w_idle & if_req & (~w_data_pend | w_starved);
    assign w_grant_mem = w_idle & w_data_pend & ~w_grant_if;
    assign w_store     = w_grant_mem & mem_wr[0];

    assign ram_ce    = w_grant_if | w_grant_mem;
    assign ram_we    = w_store;
    assign ram_addr  = w_grant_if ? if_addr : (w_grant_mem ? mem_addr : 16'h0000);
    assign ram_wdata = w_store ? mem_wdata : 16'h0000;

    assign if_data   = r_if_data;
    assign if_ack    = r_if_ack;
    assign mem_rdata = r_mem_rdata;
    assign mem_ack   = r_mem_ack;
    assign stall_req = (if_req & ~r_if_ack) | (w_data_pend & ~r_mem_ack);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_NONE;
            r_starve_cnt <= 4'd0;
            r_if_data    <= 16'h0000;
            r_mem_rdata  <= 16'h0000;
            r_if_ack     <= 1'b0;
            r_mem_ack    <= 1'b0;
        end else begin
            r_if_ack  <= 1'b0;
            r_mem_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_if) begin
                        r_owner      <= OWN_IF;
                        r_state      <= ST_RD_WAIT;
                        r_starve_cnt <= 4'd0;
                    end else if (w_grant_mem) begin
                        r_owner <= OWN_MEM;
                        // A store completes on the strobe itself, so its ack goes out next cycle.
                        if (w_store) begin
                            r_state   <= ST_RESP;
                            r_mem_ack <= 1'b1;
                        end else begin
                            r_state <= ST_RD_WAIT;
                        end
                        if (if_req) begin
                            r_starve_cnt <= w_starved ? r_starve_cnt : r_starve_cnt + 4'd1;
                        end else begin
                            r_starve_cnt <= 4'd0;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    case (r_owner)
                        OWN_IF: begin
                            r_if_data <= ram_rdata;
                            r_if_ack  <= 1'b1;
                        end
                        OWN_MEM: begin
                            r_mem_rdata <= ram_rdata;
                            r_mem_ack   <= 1'b1;
                        end
                        default: ;
                    endcase
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    r_owner <= OWN_NONE;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_owner <= OWN_NONE;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
